// File: rtl/surf4_hk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : surf4_hk_pkg
// Purpose  : Shared constants for the SURF4 housekeeping path: buffer and
//            WISHBONE address widths, DMA FSM state encoding, header magic
//            and the header word builder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package surf4_hk_pkg;

  localparam int HK_BUF_AW = 8;
  localparam int HK_WB_AW  = 20;

  localparam logic [7:0] HK_HDR_MAGIC = 8'hA5;

  typedef logic [2:0] hk_state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_LAT  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Frame header: magic, current frame count, frame length in words.
  function automatic logic [31:0] hk_header(input logic [15:0] cnt,
                                            input logic [7:0]  len);
    return {HK_HDR_MAGIC, cnt, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/surf4_pps_sync.sv
`default_nettype none
// ============================================================================
// Module   : surf4_pps_sync
// Purpose  : Brings an asynchronous PPS into the clk domain through a 2-flop
//            synchronizer and produces a one-cycle pulse on its rising edge.
// Ports    : clk   in  system clock
//            rst   in  asynchronous active-high reset
//            din   in  asynchronous PPS input
//            pulse out one-cycle pulse per synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module surf4_pps_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // sh[0], sh[1]: metastability chain; sh[2]: previous synchronized level.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= 3'b000;
    else     sh <= {sh[1:0], din};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule
`default_nettype wire

// File: rtl/surf4_hk_dma.sv
`default_nettype none
// ============================================================================
// Module   : surf4_hk_dma
// Purpose  : On each PPS, copies one completed housekeeping frame from the
//            collector buffer (synchronous read port) to a WISHBONE
//            destination, one classic write per word. Tracks busy/done,
//            sticky bus-error and PPS-overrun flags and a frame counter.
// Config   : HK_DMA_HEADER_EN - when defined, each frame is preceded by a
//            header word {A5, frame_cnt, len} written at the base address and
//            data words shift up by one word.
// Ports    : clk_i/rst_i         clock, async active-high reset
//            pps_i               asynchronous PPS
//            cfg_en_i            enable (low clears err_o/ovr_o)
//            cfg_base_i/len_i    destination byte address, length in words
//            hk_ready_i          collector has a complete frame
//            buf_en_o/adr_o/dat_i buffer read port (1-cycle latency)
//            wbm_*               WISHBONE classic write master
//            busy_o/done_o       frame in progress / completion pulse
//            err_o/ovr_o         sticky bus error / PPS-while-busy
//            frame_cnt_o         completed-frame counter
// Revision : 1.0 - initial release
// ============================================================================
module surf4_hk_dma
  import surf4_hk_pkg::*;
#(
  parameter int BUF_AW = HK_BUF_AW,
  parameter int ADR_W  = HK_WB_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pps_i,
  input  logic              cfg_en_i,
  input  logic [ADR_W-1:0]  cfg_base_i,
  input  logic [BUF_AW-1:0] cfg_len_i,
  input  logic              hk_ready_i,
  output logic              buf_en_o,
  output logic [BUF_AW-1:0] buf_adr_o,
  input  logic [31:0]       buf_dat_i,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADR_W-1:0]  wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovr_o,
  output logic [15:0]       frame_cnt_o
);

  localparam logic [ADR_W-1:0] ALIGN_MASK = ~ADR_W'(3);
`ifdef HK_DMA_HEADER_EN
  localparam logic [ADR_W-1:0] DATA_OFS = ADR_W'(4);
`else
  localparam logic [ADR_W-1:0] DATA_OFS = '0;
`endif

  hk_state_t         state;
  logic [BUF_AW-1:0] idx;
  logic [BUF_AW-1:0] len_q;
  logic [ADR_W-1:0]  base_q;
  logic              pps_pulse;
  logic              last_word;
  logic              hdr_active;
  logic              start;
  logic [ADR_W-1:0]  word_adr;

  surf4_pps_sync u_pps_sync (
    .clk   (clk_i),
    .rst   (rst_i),
    .din   (pps_i),
    .pulse (pps_pulse)
  );

  assign start     = pps_pulse & cfg_en_i & hk_ready_i;
  assign last_word = (idx == len_q - 1'b1);
  assign word_adr  = base_q + DATA_OFS + ADR_W'({idx, 2'b00});

  // Bus/buffer strobes decode straight from the state register, so an
  // asynchronous reset removes them in the same cycle.
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign buf_en_o  = (state == ST_RD);
  assign buf_adr_o = idx;
  assign wbm_cyc_o = (state == ST_WR);
  assign wbm_stb_o = (state == ST_WR);
  assign wbm_we_o  = (state == ST_WR);
  assign wbm_sel_o = {4{state == ST_WR}};

`ifdef HK_DMA_HEADER_EN
  logic hdr_q;

  // Marks that the WR in flight is the header rather than a data word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hdr_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      hdr_q <= 1'b1;
    end else if (state == ST_WR && (wbm_ack_i || wbm_err_i)) begin
      hdr_q <= 1'b0;
    end
  end

  assign hdr_active = hdr_q;
`else
  assign hdr_active = 1'b0;
`endif

  // Sticky flags: clearing via cfg_en_i low takes priority over setting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
      ovr_o <= 1'b0;
    end else if (!cfg_en_i) begin
      err_o <= 1'b0;
      ovr_o <= 1'b0;
    end else begin
      if (pps_pulse && state != ST_IDLE) ovr_o <= 1'b1;
      if (state == ST_WR && wbm_err_i)   err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      frame_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q <= cfg_base_i & ALIGN_MASK;
            len_q  <= cfg_len_i;
            idx    <= '0;
`ifdef HK_DMA_HEADER_EN
            wbm_adr_o <= cfg_base_i & ALIGN_MASK;
            wbm_dat_o <= hk_header(frame_cnt_o, 8'(cfg_len_i));
            state     <= ST_WR;
`else
            state <= (cfg_len_i == '0) ? ST_DONE : ST_RD;
`endif
          end
        end
        ST_RD: begin
          state <= ST_LAT;
        end
        ST_LAT: begin
          wbm_dat_o <= buf_dat_i;
          wbm_adr_o <= word_adr;
          state     <= ST_WR;
        end
        ST_WR: begin
          // err wins over a simultaneous ack
          if (wbm_err_i) begin
            state <= ST_IDLE;
          end else if (wbm_ack_i) begin
            if (hdr_active) begin
              state <= (len_q == '0) ? ST_DONE : ST_RD;
            end else if (last_word) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          frame_cnt_o <= frame_cnt_o + 16'd1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_surf4_hk_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_surf4_hk_dma
// Purpose  : Directed self-checking bench for surf4_hk_dma (default build,
//            no header). Provides a buffer model and a WISHBONE slave with
//            programmable wait states and error injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_surf4_hk_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps = 1'b0;
  logic        cfg_en = 1'b1;
  logic [19:0] cfg_base = '0;
  logic [7:0]  cfg_len = '0;
  logic        hk_ready = 1'b1;
  logic        buf_en;
  logic [7:0]  buf_adr;
  logic [31:0] buf_dat = '0;
  logic        cyc, stb, we;
  logic [19:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack, werr;
  logic        busy, done, err, ovr;
  logic [15:0] fcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  surf4_hk_dma dut (
    .clk_i(clk), .rst_i(rst), .pps_i(pps), .cfg_en_i(cfg_en),
    .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .hk_ready_i(hk_ready),
    .buf_en_o(buf_en), .buf_adr_o(buf_adr), .buf_dat_i(buf_dat),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_err_i(werr),
    .busy_o(busy), .done_o(done), .err_o(err), .ovr_o(ovr),
    .frame_cnt_o(fcnt)
  );

  // ---------------- buffer and slave models, activity counters ----------
  logic [31:0] bufmem [0:255];
  logic [19:0] log_adr [0:255];
  logic [31:0] log_dat [0:255];
  int ws = 0;
  int err_at = -1;
  int wcnt = 0;
  int wr_n = 0, busy_n = 0, done_n = 0, cyc_n = 0, stb_n = 0, unstable_n = 0;
  logic        in_prev = 1'b0;
  logic [19:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;

  assign ack  = cyc && stb && (wcnt == ws) && (err_at != wr_n);
  assign werr = cyc && stb && (wcnt == ws) && (err_at == wr_n);

  always @(posedge clk) begin
    if (buf_en) buf_dat <= bufmem[buf_adr];
    if (busy) busy_n <= busy_n + 1;
    if (done) done_n <= done_n + 1;
    if (cyc)  cyc_n  <= cyc_n + 1;
    if (cyc && stb) begin
      stb_n <= stb_n + 1;
      wcnt  <= (ack || werr) ? 0 : wcnt + 1;
      if (ack) begin
        log_adr[wr_n[7:0]] <= adr;
        log_dat[wr_n[7:0]] <= dat;
        wr_n <= wr_n + 1;
      end
      if (in_prev && (adr != prev_adr || dat != prev_dat))
        unstable_n <= unstable_n + 1;
      in_prev  <= 1'b1;
      prev_adr <= adr;
      prev_dat <= dat;
    end else begin
      wcnt    <= 0;
      in_prev <= 1'b0;
    end
  end

  // Raise PPS, wait (bounded) for the frame to start and finish.
  task automatic run_frame(output bit ok);
    int n;
    ok = 1'b1;
    pps = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    if (!busy) ok = 1'b0;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (busy) ok = 1'b0;
    pps = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, err, ovr} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, err, ovr}); end
    checks++; if (fcnt !== 16'd0) begin errors++;
      $display("FAIL reset_fcnt got=%h exp=0000", fcnt); end
    checks++; if ({cyc, stb, we, sel, buf_en} !== 8'h00) begin errors++;
      $display("FAIL reset_bus got=%b exp=0", {cyc, stb, we, sel, buf_en}); end
    checks++; if (adr !== 20'h0 || dat !== 32'h0 || buf_adr !== 8'h0) begin errors++;
      $display("FAIL reset_regs adr=%h dat=%h badr=%h exp=0", adr, dat, buf_adr); end
  endtask

  task automatic test_basic;
    bit ok;
    int w0 = wr_n, b0 = busy_n, d0 = done_n;
    logic [31:0] exp_d [0:3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    ws = 0; cfg_base = 20'h01000; cfg_len = 8'd4;
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=0 exp=1"); end
    checks++; if (wr_n - w0 != 4) begin errors++;
      $display("FAIL basic_nwrites got=%0d exp=4", wr_n - w0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_adr[w0+i] !== 20'h01000 + 20'(4*i) || log_dat[w0+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_word%0d got=%h@%h exp=%h@%h", i, log_dat[w0+i],
                 log_adr[w0+i], exp_d[i], 20'h01000 + 20'(4*i));
      end
    end
    checks++; if (done_n - d0 != 1) begin errors++;
      $display("FAIL basic_done got=%0d exp=1", done_n - d0); end
    checks++; if (fcnt !== 16'd1) begin errors++;
      $display("FAIL basic_fcnt got=%0d exp=1", fcnt); end
    checks++; if (busy_n - b0 != 13) begin errors++;
      $display("FAIL basic_busy got=%0d exp=13", busy_n - b0); end
  endtask

  task automatic test_wait_states;
    bit ok;
    int w0 = wr_n, b0 = busy_n, d0 = done_n, s0 = stb_n, u0 = unstable_n;
    ws = 3; cfg_base = 20'h02000; cfg_len = 8'd2;
    bufmem[0] = 32'hCAFE0001; bufmem[1] = 32'hCAFE0002;
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_timeout got=0 exp=1"); end
    checks++; if (stb_n - s0 != 8) begin errors++;
      $display("FAIL wait_stb_cycles got=%0d exp=8", stb_n - s0); end
    checks++; if (unstable_n - u0 != 0) begin errors++;
      $display("FAIL wait_stable got=%0d exp=0", unstable_n - u0); end
    checks++; if (log_adr[w0+1] !== 20'h02004 || log_dat[w0+1] !== 32'hCAFE0002) begin
      errors++; $display("FAIL wait_word1 got=%h@%h exp=cafe0002@02004",
                         log_dat[w0+1], log_adr[w0+1]); end
    checks++; if (done_n - d0 != 1 || fcnt !== 16'd2) begin errors++;
      $display("FAIL wait_done got=%0d/%0d exp=1/2", done_n - d0, fcnt); end
    checks++; if (busy_n - b0 != 13) begin errors++;
      $display("FAIL wait_busy got=%0d exp=13", busy_n - b0); end
    bufmem[0] = 32'h11; bufmem[1] = 32'h22;
  endtask

  task automatic test_bus_error;
    bit ok;
    int w0 = wr_n, d0 = done_n;
    ws = 0; cfg_base = 20'h01000; cfg_len = 8'd4; err_at = wr_n + 1;
    run_frame(ok);
    err_at = -1;
    checks++; if (!ok) begin errors++; $display("FAIL err_timeout got=0 exp=1"); end
    checks++; if (err !== 1'b1 || cyc !== 1'b0) begin errors++;
      $display("FAIL err_flag err=%b cyc=%b exp=1/0", err, cyc); end
    checks++; if (done_n - d0 != 0 || fcnt !== 16'd2 || wr_n - w0 != 1) begin errors++;
      $display("FAIL err_effects done=%0d fcnt=%0d wr=%0d exp=0/2/1",
               done_n - d0, fcnt, wr_n - w0); end
    cfg_en = 1'b0;
    @(negedge clk);
    cfg_en = 1'b1;
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL err_clear got=%b exp=0", err); end
  endtask

  task automatic test_overrun;
    int n;
    int w0 = wr_n, b0 = busy_n, d0 = done_n;
    ws = 3; cfg_base = 20'h03000; cfg_len = 8'd4;
    pps = 1'b1;
    n = 0; while (!busy && n < 20) begin @(negedge clk); n++; end
    pps = 1'b0;
    repeat (3) @(negedge clk);
    pps = 1'b1;
    n = 0; while (busy && n < 400) begin @(negedge clk); n++; end
    checks++; if (busy) begin errors++; $display("FAIL ovr_timeout got=1 exp=0"); end
    checks++; if (ovr !== 1'b1) begin errors++;
      $display("FAIL ovr_flag got=%b exp=1", ovr); end
    checks++; if (wr_n - w0 != 4 || log_adr[w0+3] !== 20'h0300C) begin errors++;
      $display("FAIL ovr_writes got=%0d last=%h exp=4 0300c", wr_n - w0, log_adr[w0+3]); end
    repeat (10) @(negedge clk);
    pps = 1'b0;
    checks++; if (busy_n - b0 != 25 || done_n - d0 != 1 || fcnt !== 16'd3) begin
      errors++; $display("FAIL ovr_single busy=%0d done=%0d fcnt=%0d exp=25/1/3",
                         busy_n - b0, done_n - d0, fcnt); end
    cfg_en = 1'b0;
    @(negedge clk);
    cfg_en = 1'b1;
    checks++; if (ovr !== 1'b0) begin errors++;
      $display("FAIL ovr_clear got=%b exp=0", ovr); end
  endtask

  task automatic test_not_ready_len0;
    bit ok;
    int c0 = cyc_n, b0 = busy_n, d0 = done_n;
    ws = 0; hk_ready = 1'b0; cfg_len = 8'd4;
    pps = 1'b1; repeat (8) @(negedge clk);
    pps = 1'b0; repeat (4) @(negedge clk);
    checks++; if (cyc_n != c0 || busy_n != b0 || done_n != d0) begin errors++;
      $display("FAIL notready cyc=%0d busy=%0d done=%0d exp=0/0/0",
               cyc_n - c0, busy_n - b0, done_n - d0); end
    hk_ready = 1'b1; cfg_len = 8'd0;
    run_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_timeout got=0 exp=1"); end
    checks++; if (cyc_n != c0 || done_n - d0 != 1 || busy_n - b0 != 1) begin errors++;
      $display("FAIL len0 cyc=%0d done=%0d busy=%0d exp=0/1/1",
               cyc_n - c0, done_n - d0, busy_n - b0); end
    checks++; if (fcnt !== 16'd4) begin errors++;
      $display("FAIL len0_fcnt got=%0d exp=4", fcnt); end
  endtask

  task automatic test_wrap_and_reset;
    bit ok;
    int n;
    int w0 = wr_n;
    logic [19:0] exp_a [0:3];
    exp_a[0] = 20'hFFFF8; exp_a[1] = 20'hFFFFC; exp_a[2] = 20'h00000; exp_a[3] = 20'h00004;
    ws = 0; cfg_base = 20'hFFFF8; cfg_len = 8'd4;
    run_frame(ok);
    checks++; if (!ok || wr_n - w0 != 4) begin errors++;
      $display("FAIL wrap_run ok=%b wr=%0d exp=1/4", ok, wr_n - w0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_adr[w0+i] !== exp_a[i]) begin errors++;
        $display("FAIL wrap_adr%0d got=%h exp=%h", i, log_adr[w0+i], exp_a[i]); end
    end
    checks++; if (fcnt !== 16'd5) begin errors++;
      $display("FAIL wrap_fcnt got=%0d exp=5", fcnt); end
    ws = 5; cfg_base = 20'h04000;
    pps = 1'b1;
    n = 0; while (!cyc && n < 30) begin @(negedge clk); n++; end
    pps = 1'b0;
    checks++; if (cyc !== 1'b1 || we !== 1'b1 || sel !== 4'hF) begin errors++;
      $display("FAIL midwr_bus cyc=%b we=%b sel=%h exp=1/1/f", cyc, we, sel); end
    rst = 1'b1;
    #1;
    checks++; if ({cyc, stb, busy} !== 3'b000 || fcnt !== 16'd0) begin errors++;
      $display("FAIL midwr_reset cyc/stb/busy=%b fcnt=%0d exp=000/0",
               {cyc, stb, busy}, fcnt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bufmem[i] = 32'h0;
    bufmem[0] = 32'h11; bufmem[1] = 32'h22; bufmem[2] = 32'h33; bufmem[3] = 32'h44;
    test_reset;
    test_basic;
    test_wait_states;
    test_bus_error;
    test_overrun;
    test_not_ready_len0;
    test_wrap_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
